// File: rtl/onchip_mem_pkg.sv
// Shared types and helpers for the burst-capable Avalon-MM on-chip memory slave.
package onchip_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  // Largest legal burst for a given burstcount width.
  function automatic int unsigned max_burst(input int unsigned burst_w);
    return 32'd1 << (burst_w - 32'd1);
  endfunction

  // Avalon treats burstcount 0 as a single beat.
  function automatic logic [15:0] eff_burst(input logic [15:0] burstcount);
    return (burstcount == 16'd0) ? 16'd1 : burstcount;
  endfunction

endpackage : onchip_mem_pkg

// File: rtl/onchip_mem_ram_be.sv
// Single-port, synchronous-read, byte-enabled RAM; maps onto an M9K/M10K block.
// The read port only updates on a read enable, so q holds the last read word.
module onchip_mem_ram_be #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (INIT_FILE == "") begin : g_ram
    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write and registered read on the shared port.
    always_ff @(posedge clk) begin
      if (we) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      if (re) q <= mem[addr];
    end
  end else begin : g_ram
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write and registered read on the shared port (preloaded block).
    always_ff @(posedge clk) begin
      if (we) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      if (re) q <= mem[addr];
    end
  end

endmodule : onchip_mem_ram_be

// File: rtl/onchip_mem_burst_avmm.sv
// Avalon-MM on-chip memory slave with linear bursts, pipelined reads and
// waitrequest flow control. Holds the command FSM, burst counters and the
// READ_LATENCY return pipeline around a byte-enabled block RAM.
module onchip_mem_burst_avmm
  import onchip_mem_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 10,
  parameter int    BURST_W      = 4,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                chipselect,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  input  logic                write,
  input  logic [BURST_W-1:0]  burstcount,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  input  logic                reset_req,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid
);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (BURST_W < 1 || BURST_W > 16) begin : g_bad_burst_w
    $error("BURST_W must be in 1..16");
  end

  state_t             state, state_nxt;
  logic [BURST_W-1:0] rem, rem_nxt;
  logic [ADDR_W-1:0]  addr_cnt, addr_nxt;
  logic [BURST_W-1:0] eff;
  logic               hold;
  logic               accept;
  logic               ram_we, ram_re;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_q;
  logic               v1;

  assign hold        = ~clken | reset_req;
  assign waitrequest = hold | (state == RD_BURST);
  assign accept      = (state == IDLE) & chipselect & (read | write) & ~waitrequest;
  assign eff         = BURST_W'(eff_burst(16'(burstcount)));

  // Next-state, burst counters and RAM port control.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    addr_nxt  = addr_cnt;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = addr_cnt;
    if (!hold) begin
      case (state)
        IDLE: begin
          if (accept) begin
            ram_addr = address;
            addr_nxt = address + 1'b1;
            rem_nxt  = eff - 1'b1;
            // Write wins a read/write collision; the read is dropped.
            if (write) ram_we = 1'b1;
            else       ram_re = 1'b1;
            if (eff > BURST_W'(1)) state_nxt = write ? WR_BURST : RD_BURST;
          end
        end
        RD_BURST: begin
          ram_re   = 1'b1;
          addr_nxt = addr_cnt + 1'b1;
          rem_nxt  = rem - 1'b1;
          if (rem == BURST_W'(1)) state_nxt = IDLE;
        end
        WR_BURST: begin
          if (chipselect && write) begin
            ram_we   = 1'b1;
            addr_nxt = addr_cnt + 1'b1;
            rem_nxt  = rem - 1'b1;
            if (rem == BURST_W'(1)) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state and burst counters; next values already equal current under hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rem      <= '0;
      addr_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rem      <= rem_nxt;
      addr_cnt <= addr_nxt;
    end
  end

  onchip_mem_ram_be #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .be   (byteenable),
    .wdata(writedata),
    .q    (ram_q)
  );

  // First return stage: marks that the RAM output register holds a fresh beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   v1 <= 1'b0;
    else if (!hold) v1 <= ram_re;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] d2;

    // Extra output register stage; data is loaded only with a beat so it holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (!hold) begin
        v2 <= v1;
        if (v1) d2 <= ram_q;
      end
    end

    assign readdata      = d2;
    assign readdatavalid = v2 & ~hold;
  end else begin : g_lat1
    logic [DATA_W-1:0] last_q;

    // The RAM output register cannot be reset, so a shadow copy supplies the
    // held/reset value of readdata between beats.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          last_q <= '0;
      else if (!hold && v1)  last_q <= ram_q;
    end

    assign readdata      = v1 ? ram_q : last_q;
    assign readdatavalid = v1 & ~hold;
  end

  a_rw_collision : assert property (@(posedge clk) disable iff (!reset_n)
    !(accept && read && write))
    else $warning("read and write accepted together; read ignored");

  a_burst_range : assert property (@(posedge clk) disable iff (!reset_n)
    accept |-> (32'(eff) <= max_burst(BURST_W)))
    else $error("burstcount exceeds maximum burst length");

endmodule : onchip_mem_burst_avmm
